// File: rtl/n2r_pkg.sv
// n2r_pkg: shared derivations for the normal-to-ready stream buffer.
//   tile_rows()     rows per tile (BLOCK_SIZE * NUM_CORES)
//   num_blks()      column blocks per row (COL / BLOCK_SIZE)
//   cores_for_col() preferred MAC core count for a given matrix width
//   idx_w()         index width for a counter over n values, never below 1
package n2r_pkg;

  function automatic int tile_rows(int block_size, int num_cores);
    return block_size * num_cores;
  endfunction

  function automatic int num_blks(int col, int block_size);
    return col / block_size;
  endfunction

  function automatic int cores_for_col(int col);
    case (col)
      2754:    return 9;
      256:     return 8;
      200:     return 5;
      64:      return 4;
      default: return 2;
    endcase
  endfunction

  // A single-valued counter still needs one bit so ports never collapse to zero width.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/n2r_stream_buffer_if.sv
// n2r_stream_buffer_if: row-in / column-block-out streaming bus.
//   in_valid/in_ready/in_data            one matrix row per beat, column 0 in MSBs
//   out_valid/out_ready/out_data         one column block of a tile, tile row 0 in MSBs
//   out_blk_idx/out_last_blk/out_last_tile  position tags of the current out beat
// master = producer of rows / consumer of blocks, slave = the buffer.
interface n2r_stream_buffer_if
  import n2r_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int BLOCK_SIZE = 2,
  parameter int NUM_CORES  = 2,
  parameter int COL        = 6
);
  localparam int TILE_ROWS = tile_rows(BLOCK_SIZE, NUM_CORES);
  localparam int NUM_BLKS  = num_blks(COL, BLOCK_SIZE);
  localparam int BLK_W     = idx_w(NUM_BLKS);

  logic                              in_valid;
  logic                              in_ready;
  logic [WIDTH*COL-1:0]              in_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [WIDTH*BLOCK_SIZE*TILE_ROWS-1:0] out_data;
  logic [BLK_W-1:0]                  out_blk_idx;
  logic                              out_last_blk;
  logic                              out_last_tile;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_blk_idx, out_last_blk, out_last_tile
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_blk_idx, out_last_blk, out_last_tile
  );

endinterface

// File: rtl/n2r_bank.sv
// n2r_bank: one tile store of the ping-pong pair.
//   clk, rst_n          clock, synchronous active-low reset (clears full only)
//   wr_en/wr_row/wr_data row write port
//   set_full/clr_full   tile complete / tile drained strobes
//   full                tile held and ready to drain
//   rd_blk/rd_data      column-block read mux, tile row 0 in MSBs
module n2r_bank
  import n2r_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int COL        = 6,
  parameter int BLOCK_SIZE = 2,
  parameter int TILE_ROWS  = 4,
  localparam int NUM_BLKS  = num_blks(COL, BLOCK_SIZE),
  localparam int ROW_W     = idx_w(TILE_ROWS),
  localparam int BLK_W     = idx_w(NUM_BLKS),
  localparam int RW        = WIDTH * COL,
  localparam int SW        = WIDTH * BLOCK_SIZE,
  localparam int OW        = SW * TILE_ROWS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [RW-1:0]    wr_data,
  input  logic             set_full,
  input  logic             clr_full,
  input  logic [BLK_W-1:0] rd_blk,
  output logic             full,
  output logic [OW-1:0]    rd_data
);

  logic [RW-1:0] mem_q [TILE_ROWS];
  logic          full_q, full_d;
  logic [RW-1:0] row_sh;

  // Row storage is deliberately not reset; the full flag alone qualifies it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_row] <= wr_data;
  end

  // set and clr never coincide: set needs an empty bank, clr a full one.
  always_comb begin
    full_d = full_q;
    if (set_full)      full_d = 1'b1;
    else if (clr_full) full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) full_q <= 1'b0;
    else        full_q <= full_d;
  end

  assign full = full_q;

  // Block b of a row sits (NUM_BLKS-1-b) block-widths above the LSB since column 0 is in the MSBs.
  always_comb begin
    rd_data = '0;
    row_sh  = '0;
    for (int i = 0; i < TILE_ROWS; i++) begin
      row_sh = mem_q[i] >> (SW * (NUM_BLKS - 1 - int'(rd_blk)));
      rd_data[(TILE_ROWS-1-i)*SW +: SW] = row_sh[SW-1:0];
    end
  end

endmodule

// File: rtl/n2r_stream_buffer.sv
// n2r_stream_buffer: groups incoming matrix rows into tiles of
// BLOCK_SIZE*NUM_CORES rows in two ping-pong banks and replays each tile
// as COL/BLOCK_SIZE column-block beats for the multi-core MAC array.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         n2r_stream_buffer_if slave: row input, block output, position tags
// FRAC_WIDTH is carried for the datapath's benefit only; data is never interpreted.
module n2r_stream_buffer
  import n2r_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int BLOCK_SIZE = 2,
  parameter int NUM_CORES  = 2,
  parameter int ROW        = 8,
  parameter int COL        = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  n2r_stream_buffer_if.slave   bus
);

  localparam int TILE_ROWS = tile_rows(BLOCK_SIZE, NUM_CORES);
  localparam int NUM_BLKS  = num_blks(COL, BLOCK_SIZE);
  localparam int NUM_TILES = ROW / TILE_ROWS;
  localparam int ROW_W     = idx_w(TILE_ROWS);
  localparam int BLK_W     = idx_w(NUM_BLKS);
  localparam int TILE_W    = idx_w(NUM_TILES);
  localparam int OW        = WIDTH * BLOCK_SIZE * TILE_ROWS;

  if (ROW % TILE_ROWS != 0) begin : g_bad_row
    $error("n2r_stream_buffer: ROW must be a multiple of BLOCK_SIZE*NUM_CORES");
  end
  if (COL % BLOCK_SIZE != 0) begin : g_bad_col
    $error("n2r_stream_buffer: COL must be a multiple of BLOCK_SIZE");
  end
  if (FRAC_WIDTH > WIDTH) begin : g_bad_frac
    $error("n2r_stream_buffer: FRAC_WIDTH cannot exceed WIDTH");
  end

  logic              wr_bank_q, wr_bank_d;
  logic [ROW_W-1:0]  wr_row_q,  wr_row_d;
  logic [TILE_W-1:0] wr_tile_q, wr_tile_d;
  logic              rd_bank_q, rd_bank_d;
  logic [BLK_W-1:0]  rd_blk_q,  rd_blk_d;
  logic [TILE_W-1:0] rd_tile_q, rd_tile_d;

  logic [1:0]        full;
  logic [OW-1:0]     bank_rd_data [2];
  logic              in_ready, out_valid;
  logic              in_fire, out_fire;
  logic              wr_last, rd_last;

  assign in_ready  = ~full[wr_bank_q];
  assign out_valid = full[rd_bank_q];
  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = out_valid & bus.out_ready;
  assign wr_last   = (wr_row_q == ROW_W'(TILE_ROWS - 1));
  assign rd_last   = (rd_blk_q == BLK_W'(NUM_BLKS - 1));

  // Write and read sides advance independently; on the same edge they
  // always address different banks, so both updates simply apply.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    wr_tile_d = wr_tile_q;
    rd_bank_d = rd_bank_q;
    rd_blk_d  = rd_blk_q;
    rd_tile_d = rd_tile_q;
    if (in_fire) begin
      if (wr_last) begin
        wr_row_d  = '0;
        wr_bank_d = ~wr_bank_q;
        wr_tile_d = (wr_tile_q == TILE_W'(NUM_TILES - 1)) ? '0 : wr_tile_q + TILE_W'(1);
      end else begin
        wr_row_d  = wr_row_q + ROW_W'(1);
      end
    end
    if (out_fire) begin
      if (rd_last) begin
        rd_blk_d  = '0;
        rd_bank_d = ~rd_bank_q;
        rd_tile_d = (rd_tile_q == TILE_W'(NUM_TILES - 1)) ? '0 : rd_tile_q + TILE_W'(1);
      end else begin
        rd_blk_d  = rd_blk_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      wr_row_q  <= '0;
      wr_tile_q <= '0;
      rd_bank_q <= 1'b0;
      rd_blk_q  <= '0;
      rd_tile_q <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      wr_tile_q <= wr_tile_d;
      rd_bank_q <= rd_bank_d;
      rd_blk_q  <= rd_blk_d;
      rd_tile_q <= rd_tile_d;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_bank
    localparam logic BANK_ID = 1'(k);
    n2r_bank #(
      .WIDTH      (WIDTH),
      .COL        (COL),
      .BLOCK_SIZE (BLOCK_SIZE),
      .TILE_ROWS  (TILE_ROWS)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (in_fire & (wr_bank_q == BANK_ID)),
      .wr_row   (wr_row_q),
      .wr_data  (bus.in_data),
      .set_full (in_fire & wr_last & (wr_bank_q == BANK_ID)),
      .clr_full (out_fire & rd_last & (rd_bank_q == BANK_ID)),
      .rd_blk   (rd_blk_q),
      .full     (full[k]),
      .rd_data  (bank_rd_data[k])
    );
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_data      = bank_rd_data[rd_bank_q];
  assign bus.out_blk_idx   = rd_blk_q;
  // Tags are qualified by out_valid so an idle output never advertises a last beat.
  assign bus.out_last_blk  = out_valid & rd_last;
  assign bus.out_last_tile = out_valid & (rd_tile_q == TILE_W'(NUM_TILES - 1));

endmodule
